extension_sequencer: RTL and testbench
======================================

# extension_sequencer

Multi-cycle sequencer directly downstream of the extension-opcode decoder. It takes a decoded extension instruction (module select from funct3, two operands, destination register) and holds the pipeline while it dispatches the operation to one of up to `NUM_EXT` extension modules over a valid/ready request and response handshake. When the module responds, it returns the result to the register file as a single-cycle writeback pulse.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `NUM_EXT`, 8, number of attached extension modules (1..8); select values ≥ `NUM_EXT` are illegal
- `TIMEOUT`, 255, cycle limit in ISSUE+WAIT (used only with `EXT_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ext_start`  in  1  decoded extension instruction present this cycle
- `ext_select`  in  3  target module (funct3)
- `rs1_data`, `rs2_data`  in  XLEN  operands
- `rd_addr`  in  5  destination register
- `stall`  out  1  hold PC/pipeline
- `wb_valid`  out  1  one-cycle writeback strobe
- `wb_addr`  out  5  writeback register
- `wb_data`  out  XLEN  writeback value
- `ext_req_valid`  out  NUM_EXT  one-hot request to module
- `ext_req_ready`  in  NUM_EXT  module accepts request
- `ext_op_a`, `ext_op_b`  out  XLEN  latched operands to modules
- `ext_resp_valid`  in  NUM_EXT  module result valid
- `ext_resp_data`  in  NUM_EXT*XLEN  module i result at bits [XLEN*i+XLEN-1 : XLEN*i]
- `ext_err`  out  1  timeout flag, coincident with `wb_valid`

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset puts the FSM in IDLE and sets all registered outputs to 0.
- IDLE:
  - On `ext_start`, latch select, `rs1_data`/`rs2_data` (onto `ext_op_a`/`ext_op_b`) and `rd_addr`.
  - Go to ISSUE, or to DONE directly if select ≥ `NUM_EXT`.
- ISSUE:
  - `ext_req_valid[sel]` = 1; all other request bits are 0.
  - Request, operands and select stay stable until `ext_req_ready[sel]` is seen.
  - On ready, go to WAIT.
  - `ext_resp_valid` is ignored in ISSUE.
- WAIT:
  - `ext_req_valid` = 0.
  - On `ext_resp_valid[sel]`, capture the matching `ext_resp_data` slice and go to DONE.
  - Response bits from non-selected modules are ignored.
- DONE:
  - `wb_valid` = 1 for exactly one cycle, with `wb_addr` = latched rd and `wb_data` = captured result.
  - Illegal select returns `wb_data` = 0.
  - If rd = 0, `wb_valid` stays 0 but the sequence still completes.
  - Next state is IDLE. `ext_start` seen in DONE is the same, now-retiring instruction and is ignored.
- `stall` = (IDLE && `ext_start`) || ISSUE || WAIT. `stall` is 0 in DONE and when idle.
- `ext_op_a`/`ext_op_b` hold their last latched value while idle.
- Reset mid-operation:
  - Return to IDLE on the next edge.
  - `ext_req_valid` drops, no writeback is issued, and any in-flight response is discarded.

## Timing
- `ext_start` at cycle T → `ext_req_valid` at T+1.
- With ready at T+1 and response at T+2, `wb_valid` occurs at T+3.
- Minimum `stall` is 3 cycles (T..T+2). Each extra cycle of ready or response delay adds one cycle.
- Illegal select: DONE at T+1, so `stall` lasts only at T.
- `wb_*`, `ext_req_valid` and `ext_err` are registered and decoded from state. `stall` is combinational from `ext_start` and state.
- A response can be accepted no earlier than the cycle after the request handshake.

## Configuration
- `EXT_TIMEOUT_EN` defined:
  - A counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT.
  - When the count reaches `TIMEOUT` without completion, the FSM goes to DONE with `wb_data` = all ones and `ext_err` = 1 for that one DONE cycle.
  - A late response arriving after the timeout is ignored.
- `EXT_TIMEOUT_EN` not defined:
  - No counter is built; the FSM waits indefinitely.
  - `ext_err` is tied to 0.

## Test plan
- Basic: `ext_start`, select=2, rs1=0x1234, rs2=0x5678, rd=5; module 2 ready at once and responds 0xDEADBEEF next cycle → `stall` high 3 cycles, `ext_op_a`=0x1234, `wb_valid` at T+3 with addr 5, data 0xDEADBEEF.
- Backpressure: select=0; ready held low 4 cycles then high, response 2 cycles later → `ext_req_valid[0]` stable for 5 cycles, operands unchanged, single `wb_valid`.
- Cross-talk and rd=0: select=1; module 3 asserts `resp_valid` with 0xBAD first, module 1 later responds 0x7 → writeback 0x7. Repeat with rd=0 → no `wb_valid`, `stall` still released.
- Illegal select with `NUM_EXT`=4: select=6 → no request bit set, `wb_valid` at T+1 with data 0.
- Reset mid-WAIT: assert `rst` one cycle; module responds after reset → `ext_req_valid`=0, no `wb_valid`, FSM idle. A following instruction completes normally.
- With `EXT_TIMEOUT_EN`, `TIMEOUT`=10: module never ready → `wb_valid` and `ext_err` together at T+11, data 0xFFFFFFFF.

Source files
------------

// File: rtl/extension_sequencer_if.sv
// extension_sequencer_if: request/response bus between the sequencer and its extension modules
interface extension_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int NUM_EXT = 8
);
  logic [NUM_EXT-1:0]      ext_req_valid;
  logic [NUM_EXT-1:0]      ext_req_ready;
  logic [XLEN-1:0]         ext_op_a;
  logic [XLEN-1:0]         ext_op_b;
  logic [NUM_EXT-1:0]      ext_resp_valid;
  logic [NUM_EXT*XLEN-1:0] ext_resp_data;
  modport master (
    output ext_req_valid, ext_op_a, ext_op_b,
    input  ext_req_ready, ext_resp_valid, ext_resp_data
  );
  modport slave (
    input  ext_req_valid, ext_op_a, ext_op_b,
    output ext_req_ready, ext_resp_valid, ext_resp_data
  );
endinterface

// File: rtl/extension_sequencer.sv
// extension_sequencer: dispatches decoded extension ops to NUM_EXT modules and writes back the result
// Optional EXT_TIMEOUT_EN aborts ISSUE/WAIT after TIMEOUT cycles with an all-ones result and ext_err.
module extension_sequencer #(
  parameter int XLEN    = 32,
  parameter int NUM_EXT = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ext_start,
  input  logic [2:0]           ext_select,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [4:0]           rd_addr,
  output logic                 stall,
  output logic                 wb_valid,
  output logic [4:0]           wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic                 ext_err,
  extension_sequencer_if.master ext
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] NE = 4'(NUM_EXT);
  state_t r_state, w_next;
  logic [2:0]          r_sel, w_sel;
  logic [4:0]          r_rd, w_rd;
  logic [XLEN-1:0]     r_op_a, r_op_b, r_wb_data, w_wb_data, w_resp;
  logic [NUM_EXT-1:0]  r_req, w_req;
  logic [4:0]          r_wb_addr;
  logic                r_wb_valid, w_wb_valid, w_err, w_illegal, w_hit, w_to, w_done;
  logic [7:0]          w_rdy, w_rv, w_onehot;
  logic [8*XLEN-1:0]   w_data_pad;
  // Pad to 8 modules so select indexing stays in range for any NUM_EXT
  assign w_rdy      = 8'(ext.ext_req_ready);
  assign w_rv       = 8'(ext.ext_resp_valid);
  assign w_data_pad = (8*XLEN)'(ext.ext_resp_data);
  assign w_resp     = w_data_pad[32'(r_sel)*XLEN +: XLEN];
  assign w_hit      = w_rv[r_sel];
  assign w_illegal  = {1'b0, ext_select} >= NE;
`ifdef EXT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  always_ff @(posedge clk)
    if (rst || r_state == IDLE) r_cnt <= '0;
    else if (r_state == ISSUE || r_state == WAIT) r_cnt <= r_cnt + 1'b1;
  always_ff @(posedge clk)
    r_err <= rst ? 1'b0 : w_err;
  assign w_to    = (r_state == ISSUE || r_state == WAIT) && r_cnt == CW'(TIMEOUT - 1);
  assign ext_err = r_err;
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_to    = 1'b0;
  assign ext_err = 1'b0;
`endif
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ext_start ? (w_illegal ? DONE : ISSUE) : IDLE;
      ISSUE:   w_next = w_to ? DONE : (w_rdy[r_sel] ? WAIT : ISSUE);
      WAIT:    w_next = (w_hit || w_to) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_sel      = r_state == IDLE ? ext_select : r_sel;
    w_rd       = r_state == IDLE ? rd_addr : r_rd;
    w_onehot   = 8'd1 << w_sel;
    w_req      = w_next == ISSUE ? NUM_EXT'(w_onehot) : '0;
    w_done     = w_next == DONE;
    w_err      = w_done && (r_state == ISSUE || (r_state == WAIT && !w_hit));
    w_wb_valid = w_done && w_rd != 5'd0;
    w_wb_data  = !w_done ? '0 : w_err ? '1 : r_state == WAIT ? w_resp : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_sel      <= '0;
      r_rd       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_req      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_req      <= w_req;
      r_wb_valid <= w_wb_valid;
      r_wb_addr  <= w_done ? w_rd : 5'd0;
      r_wb_data  <= w_wb_data;
      if (r_state == IDLE && ext_start) begin
        r_sel  <= ext_select;
        r_rd   <= rd_addr;
        r_op_a <= rs1_data;
        r_op_b <= rs2_data;
      end
    end
  assign stall             = (r_state == IDLE && ext_start) || r_state == ISSUE || r_state == WAIT;
  assign wb_valid          = r_wb_valid;
  assign wb_addr           = r_wb_addr;
  assign wb_data           = r_wb_data;
  assign ext.ext_req_valid = r_req;
  assign ext.ext_op_a      = r_op_a;
  assign ext.ext_op_b      = r_op_b;
endmodule

// File: tb/tb_extension_sequencer.sv
// tb_extension_sequencer: directed checks of the extension sequencer with four attached modules
module tb_extension_sequencer;
  localparam int XLEN = 32;
  localparam int NE   = 4;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ext_start = 1'b0;
  logic [2:0]      ext_select = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [4:0]      rd_addr = '0;
  logic            stall, wb_valid, ext_err;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  int errors = 0;
  int checks = 0;
  extension_sequencer_if #(.XLEN(XLEN), .NUM_EXT(NE)) bus ();
  extension_sequencer #(.XLEN(XLEN), .NUM_EXT(NE), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .ext_start(ext_start), .ext_select(ext_select),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ext_err(ext_err), .ext(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ext_start  = 1'b1;
    ext_select = s;
    rs1_data   = a;
    rs2_data   = b;
    rd_addr    = rd;
  endtask
  task automatic resp(input int i, input logic [31:0] d);
    bus.ext_resp_valid = '0;
    bus.ext_resp_valid[i] = 1'b1;
    bus.ext_resp_data = '0;
    bus.ext_resp_data[i*XLEN +: XLEN] = d;
  endtask
  task automatic clr;
    ext_start          = 1'b0;
    bus.ext_req_ready  = '0;
    bus.ext_resp_valid = '0;
    bus.ext_resp_data  = '0;
  endtask
  initial begin
    clr();
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_req", bus.ext_req_valid, 0);
    chk("rst_op_a", bus.ext_op_a, 0);
    chk("rst_err", ext_err, 0);
    rst = 1'b0;
    tick();
    // basic: select 2, immediate ready, response next cycle
    start(3'd2, 32'h1234, 32'h5678, 5'd5);
    #1 chk("basic_stall_T", stall, 1);
    tick(); clr(); bus.ext_req_ready = 4'b0100;
    #1 chk("basic_req_T1", bus.ext_req_valid, 4'b0100);
    chk("basic_op_a", bus.ext_op_a, 32'h1234);
    chk("basic_op_b", bus.ext_op_b, 32'h5678);
    chk("basic_stall_T1", stall, 1);
    tick(); clr(); resp(2, 32'hDEADBEEF);
    #1 chk("basic_req_T2", bus.ext_req_valid, 0);
    chk("basic_stall_T2", stall, 1);
    chk("basic_wb_T2", wb_valid, 0);
    tick(); clr();
    #1 chk("basic_wb_T3", wb_valid, 1);
    chk("basic_addr", wb_addr, 5);
    chk("basic_data", wb_data, 32'hDEADBEEF);
    chk("basic_stall_T3", stall, 0);
    tick();
    #1 chk("basic_wb_T4", wb_valid, 0);
    chk("basic_op_hold", bus.ext_op_a, 32'h1234);
    // backpressure: ready low 4 cycles, response 2 cycles after ready
    start(3'd0, 32'hAAAA, 32'hBBBB, 5'd7);
    tick(); clr();
    for (int k = 1; k <= 4; k++) begin
      #1 chk("bp_req_stable", bus.ext_req_valid, 4'b0001);
      chk("bp_op_a", bus.ext_op_a, 32'hAAAA);
      chk("bp_wb_none", wb_valid, 0);
      tick();
    end
    bus.ext_req_ready = 4'b0001;
    #1 chk("bp_req_5th", bus.ext_req_valid, 4'b0001);
    chk("bp_op_b", bus.ext_op_b, 32'hBBBB);
    tick(); clr();
    #1 chk("bp_req_drop", bus.ext_req_valid, 0);
    tick(); resp(0, 32'h55);
    #1 chk("bp_stall_wait", stall, 1);
    chk("bp_wb_early", wb_valid, 0);
    tick(); clr();
    #1 chk("bp_wb", wb_valid, 1);
    chk("bp_data", wb_data, 32'h55);
    chk("bp_addr", wb_addr, 7);
    tick();
    #1 chk("bp_wb_single", wb_valid, 0);
    // cross-talk: module 3 responds first and must be ignored
    start(3'd1, 32'h1, 32'h2, 5'd9);
    tick(); clr(); bus.ext_req_ready = 4'b0010; resp(3, 32'hBAD);
    #1 chk("xt_req", bus.ext_req_valid, 4'b0010);
    tick(); clr(); resp(3, 32'hBAD);
    #1 chk("xt_stall_bad", stall, 1);
    tick(); clr(); resp(1, 32'h7);
    #1 chk("xt_wb_not_yet", wb_valid, 0);
    chk("xt_stall_wait", stall, 1);
    tick(); clr();
    #1 chk("xt_wb", wb_valid, 1);
    chk("xt_data", wb_data, 32'h7);
    chk("xt_addr", wb_addr, 9);
    tick();
    // rd = 0: sequence completes without a writeback strobe
    start(3'd1, 32'h3, 32'h4, 5'd0);
    tick(); clr(); bus.ext_req_ready = 4'b0010;
    tick(); clr(); resp(1, 32'h7);
    #1 chk("rd0_stall_wait", stall, 1);
    tick(); clr();
    #1 chk("rd0_no_wb", wb_valid, 0);
    chk("rd0_stall_released", stall, 0);
    tick();
    #1 chk("rd0_idle_stall", stall, 0);
    // illegal select 6 with four modules
    start(3'd6, 32'h9, 32'h9, 5'd3);
    #1 chk("ill_stall_T", stall, 1);
    tick(); clr();
    #1 chk("ill_req", bus.ext_req_valid, 0);
    chk("ill_wb", wb_valid, 1);
    chk("ill_addr", wb_addr, 3);
    chk("ill_data", wb_data, 0);
    chk("ill_stall_T1", stall, 0);
    tick();
    #1 chk("ill_wb_once", wb_valid, 0);
    // reset while waiting for a response
    start(3'd3, 32'hCAFE, 32'hF00D, 5'd4);
    tick(); clr(); bus.ext_req_ready = 4'b1000;
    tick(); clr(); rst = 1'b1;
    #1 chk("rstw_stall", stall, 1);
    tick(); rst = 1'b0; resp(3, 32'h99);
    #1 chk("rstw_req", bus.ext_req_valid, 0);
    chk("rstw_wb", wb_valid, 0);
    chk("rstw_stall_idle", stall, 0);
    tick(); clr();
    #1 chk("rstw_wb_late", wb_valid, 0);
    start(3'd2, 32'h11, 32'h22, 5'd6);
    tick(); clr(); bus.ext_req_ready = 4'b0100;
    #1 chk("post_req", bus.ext_req_valid, 4'b0100);
    tick(); clr(); resp(2, 32'h0A0B0C0D);
    tick(); clr();
    #1 chk("post_wb", wb_valid, 1);
    chk("post_data", wb_data, 32'h0A0B0C0D);
    chk("post_addr", wb_addr, 6);
    tick();
`ifdef EXT_TIMEOUT_EN
    // module never ready: abort after TIMEOUT cycles
    start(3'd1, 32'h5, 32'h6, 5'd2);
    for (int k = 1; k <= 10; k++) begin
      tick(); clr();
      #1 chk("to_wb_none", wb_valid, 0);
    end
    tick();
    #1 chk("to_wb", wb_valid, 1);
    chk("to_err", ext_err, 1);
    chk("to_data", wb_data, 32'hFFFFFFFF);
    tick();
    #1 chk("to_err_once", ext_err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
